// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the ASCII -> PS/2 Set-2 keystroke encoder.
// The character table lives here as a pure function so the ROM wrapper
// stays a single registered read.
package ps2_kbd_pkg;

  localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;
  localparam logic [7:0] SHIFT_CODE_DEF = 8'h12;
  localparam int ROM_W  = 10;  // {mapped, need_shift, code[7:0]}
  localparam int ADDR_W = 9;   // {lang, ascii[7:0]}

  typedef enum logic [3:0] {
    IDLE, LOOKUP, SHIFT_MK, KEY_MK, KEY_BRK_PFX, KEY_BRK,
    SHIFT_BRK_PFX, SHIFT_BRK, GAP
  } state_t;

  function automatic logic is_letter(input logic [7:0] ch);
    return (ch >= 8'h61 && ch <= 8'h7A) || (ch >= 8'h41 && ch <= 8'h5A);
  endfunction

  // Set-2 make codes for a..z by alphabet index.
  function automatic logic [7:0] letter_code(input logic [4:0] idx);
    logic [7:0] c;
    case (idx)
      5'd0:  c = 8'h1C;  5'd1:  c = 8'h32;  5'd2:  c = 8'h21;  5'd3:  c = 8'h23;
      5'd4:  c = 8'h24;  5'd5:  c = 8'h2B;  5'd6:  c = 8'h34;  5'd7:  c = 8'h33;
      5'd8:  c = 8'h43;  5'd9:  c = 8'h3B;  5'd10: c = 8'h42;  5'd11: c = 8'h4B;
      5'd12: c = 8'h3A;  5'd13: c = 8'h31;  5'd14: c = 8'h44;  5'd15: c = 8'h4D;
      5'd16: c = 8'h15;  5'd17: c = 8'h2D;  5'd18: c = 8'h1B;  5'd19: c = 8'h2C;
      5'd20: c = 8'h3C;  5'd21: c = 8'h2A;  5'd22: c = 8'h1D;  5'd23: c = 8'h22;
      5'd24: c = 8'h35;  5'd25: c = 8'h1A;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Inverse of the decoder table. Bank 1 is the QWERTZ layout: Y and Z
  // swap keys, everything else shares bank 0. Unmapped -> all zeros.
  function automatic logic [ROM_W-1:0] rom_lookup(input logic [ADDR_W-1:0] addr);
    logic [7:0]       ch;
    logic [4:0]       idx;
    logic             upper;
    logic [ROM_W-1:0] e;
    ch    = addr[7:0];
    e     = '0;
    idx   = '0;
    upper = 1'b0;
    if (is_letter(ch)) begin
      upper = (ch <= 8'h5A);
      idx   = upper ? 5'(ch - 8'h41) : 5'(ch - 8'h61);
      if (addr[8] && idx == 5'd24)      idx = 5'd25;
      else if (addr[8] && idx == 5'd25) idx = 5'd24;
      e = {1'b1, upper, letter_code(idx)};
    end else begin
      case (ch)
        8'h30: e = {2'b10, 8'h45};  8'h31: e = {2'b10, 8'h16};
        8'h32: e = {2'b10, 8'h1E};  8'h33: e = {2'b10, 8'h26};
        8'h34: e = {2'b10, 8'h25};  8'h35: e = {2'b10, 8'h2E};
        8'h36: e = {2'b10, 8'h36};  8'h37: e = {2'b10, 8'h3D};
        8'h38: e = {2'b10, 8'h3E};  8'h39: e = {2'b10, 8'h46};
        8'h21: e = {2'b11, 8'h16};  8'h40: e = {2'b11, 8'h1E};
        8'h23: e = {2'b11, 8'h26};  8'h24: e = {2'b11, 8'h25};
        8'h25: e = {2'b11, 8'h2E};  8'h5E: e = {2'b11, 8'h36};
        8'h26: e = {2'b11, 8'h3D};  8'h2A: e = {2'b11, 8'h3E};
        8'h28: e = {2'b11, 8'h46};  8'h29: e = {2'b11, 8'h45};
        8'h20: e = {2'b10, 8'h29};  8'h0D: e = {2'b10, 8'h5A};
        8'h2D: e = {2'b10, 8'h4E};  8'h5F: e = {2'b11, 8'h4E};
        8'h3D: e = {2'b10, 8'h55};  8'h2B: e = {2'b11, 8'h55};
        default: e = '0;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/ascii_to_scancode_seq_if.sv
// Character-in / scancode-out bus. CAPS_AWARE_EN adds caps_on.
interface ascii_to_scancode_seq_if;
  logic       ascii_valid;
  logic [7:0] ascii;
  logic       lang;
  logic       ascii_ready;
  logic       sc_valid;
  logic [7:0] sc_data;
  logic       sc_ready;
  logic       busy;
  logic       err_unmapped;
`ifdef CAPS_AWARE_EN
  logic       caps_on;
`endif

  modport master (
`ifdef CAPS_AWARE_EN
    output caps_on,
`endif
    output ascii_valid, ascii, lang, sc_ready,
    input  ascii_ready, sc_valid, sc_data, busy, err_unmapped
  );

  modport slave (
`ifdef CAPS_AWARE_EN
    input  caps_on,
`endif
    input  ascii_valid, ascii, lang, sc_ready,
    output ascii_ready, sc_valid, sc_data, busy, err_unmapped
  );
endinterface

// File: rtl/ascii_scancode_rom.sv
// Registered character -> {mapped, need_shift, code} table read.
module ascii_scancode_rom
  import ps2_kbd_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [ROM_W-1:0]  data
);
  logic [ROM_W-1:0] data_q;

  // One-cycle read, no reset needed: only consumed in LOOKUP
  always_ff @(posedge clk) data_q <= rom_lookup(addr);

  assign data = data_q;
endmodule

// File: rtl/ascii_to_scancode_seq.sv
// One character per handshake -> PS/2 Set-2 keystroke byte stream
// (shift make, key make, key break, shift break), with an idle gap after
// every transferred byte. Optional macro CAPS_AWARE_EN adds caps_on,
// which inverts the shift requirement of bank-0 letters.
module ascii_to_scancode_seq
  import ps2_kbd_pkg::*;
#(
  parameter int         GAP_CYCLES = 4,
  parameter logic [7:0] BREAK_CODE = BREAK_CODE_DEF,
  parameter logic [7:0] SHIFT_CODE = SHIFT_CODE_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  ascii_to_scancode_seq_if.slave bus
);
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t         state_q, state_d, nxt_q, nxt_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     code_q, code_d;
  logic           shift_q, shift_d;
  logic           sc_valid_q, sc_valid_d;
  logic [7:0]     sc_data_q, sc_data_d;
  logic           err_q, err_d;
  logic           rdy_q, rdy_d;
  logic           busy_q, busy_d;
  logic           need_shift;
  logic [ROM_W-1:0] rom_data;
`ifdef CAPS_AWARE_EN
  logic           caps_q, caps_d;  // caps_on applies to this character
`endif

  // The ROM samples the live request so its data is ready in LOOKUP,
  // the cycle right after accept.
  ascii_scancode_rom u_rom (
    .clk  (clk),
    .addr ({bus.lang, bus.ascii}),
    .data (rom_data)
  );

  function automatic state_t succ(input state_t s, input logic sh);
    state_t n;
    case (s)
      SHIFT_MK:      n = KEY_MK;
      KEY_MK:        n = KEY_BRK_PFX;
      KEY_BRK_PFX:   n = KEY_BRK;
      KEY_BRK:       n = sh ? SHIFT_BRK_PFX : IDLE;
      SHIFT_BRK_PFX: n = SHIFT_BRK;
      default:       n = IDLE;
    endcase
    return n;
  endfunction

  function automatic logic is_emit(input state_t s);
    return s inside {SHIFT_MK, KEY_MK, KEY_BRK_PFX, KEY_BRK, SHIFT_BRK_PFX, SHIFT_BRK};
  endfunction

  function automatic logic [7:0] byte_of(input state_t s, input logic [7:0] code);
    logic [7:0] b;
    case (s)
      SHIFT_MK, SHIFT_BRK:        b = SHIFT_CODE;
      KEY_BRK_PFX, SHIFT_BRK_PFX: b = BREAK_CODE;
      default:                    b = code;
    endcase
    return b;
  endfunction

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    shift_d = shift_q;
    err_d   = 1'b0;
`ifdef CAPS_AWARE_EN
    caps_d     = caps_q;
    need_shift = rom_data[8] ^ caps_q;
`else
    need_shift = rom_data[8];
`endif
    case (state_q)
      IDLE: begin
        if (bus.ascii_valid && rdy_q) begin
          state_d = LOOKUP;
`ifdef CAPS_AWARE_EN
          caps_d = bus.caps_on && !bus.lang && is_letter(bus.ascii);
`endif
        end
      end
      LOOKUP: begin
        if (!rom_data[9]) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          code_d  = rom_data[7:0];
          shift_d = need_shift;
          state_d = need_shift ? SHIFT_MK : KEY_MK;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = nxt_q;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        if (sc_valid_q && bus.sc_ready) begin
          if (GAP_CYCLES == 0) begin
            state_d = succ(state_q, shift_q);
          end else begin
            state_d = GAP;
            nxt_d   = succ(state_q, shift_q);
            cnt_d   = CW'(GAP_CYCLES - 1);
          end
        end
      end
    endcase
    sc_valid_d = is_emit(state_d);
    sc_data_d  = is_emit(state_d) ? byte_of(state_d, code_d) : sc_data_q;
    rdy_d      = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; reset abandons any sequence in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      nxt_q      <= IDLE;
      cnt_q      <= '0;
      code_q     <= 8'h00;
      shift_q    <= 1'b0;
      sc_valid_q <= 1'b0;
      sc_data_q  <= 8'h00;
      err_q      <= 1'b0;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef CAPS_AWARE_EN
      caps_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      nxt_q      <= nxt_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      shift_q    <= shift_d;
      sc_valid_q <= sc_valid_d;
      sc_data_q  <= sc_data_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
`ifdef CAPS_AWARE_EN
      caps_q     <= caps_d;
`endif
    end
  end

  assign bus.ascii_ready  = rdy_q;
  assign bus.sc_valid     = sc_valid_q;
  assign bus.sc_data      = sc_data_q;
  assign bus.busy         = busy_q;
  assign bus.err_unmapped = err_q;
endmodule
